// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single unified memory port.
// P (control/datapath) and D (debug/loader) share one memory bus; each access is
// latched in IDLE, held on the bus through BUSY and acknowledged for one cycle in DONE.
// Optional build macro ARB_RR_EN: round-robin tie-breaking instead of fixed P-over-D.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              p_req_i,
  input  logic              p_we_i,
  input  logic [ADDR_W-1:0] p_addr_i,
  input  logic [DATA_W-1:0] p_wdata_i,
  output logic [DATA_W-1:0] p_rdata_o,
  output logic              p_ack_o,
  output logic              p_stall_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [1:0]        owner_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [1:0] OwnNone = 2'b00;
  localparam logic [1:0] OwnP    = 2'b01;
  localparam logic [1:0] OwnD    = 2'b10;
  localparam logic [3:0] LatRd   = 4'(MEM_LAT);

  state_e              state_q, state_d;
  logic [1:0]          owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   p_rdata_q, p_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                grant_p;
  logic                sel_we;

`ifdef ARB_RR_EN
  // 1 when D took the most recent grant; the other requester wins the next tie
  logic last_d_q;

  // Tie-break: P wins unless D is alone or P won last time
  always_comb grant_p = p_req_i & (~d_req_i | last_d_q);

  // Remember the winner of each grant
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      last_d_q <= 1'b1;
    end else if (state_q == StIdle && (p_req_i || d_req_i)) begin
      last_d_q <= ~grant_p;
    end
  end
`else
  // Fixed priority: P always beats D
  assign grant_p = p_req_i;
`endif

  assign sel_we = grant_p ? p_we_i : d_we_i;

  // State and transaction registers
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      owner_q   <= OwnNone;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      p_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      p_rdata_q <= p_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Next-state: grant in IDLE, count down in BUSY, single ack cycle in DONE
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    p_rdata_d = p_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      StIdle: begin
        owner_d = OwnNone;
        if (p_req_i || d_req_i) begin
          owner_d = grant_p ? OwnP : OwnD;
          addr_d  = grant_p ? p_addr_i : d_addr_i;
          wdata_d = grant_p ? p_wdata_i : d_wdata_i;
          we_d    = sel_we;
          cnt_d   = sel_we ? 4'd1 : LatRd;
          state_d = StBusy;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (!we_q) begin
            if (owner_q == OwnP) p_rdata_d = mem_rdata_i;
            else                 d_rdata_d = mem_rdata_i;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        owner_d = OwnNone;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registers; a write spends exactly one BUSY cycle, so
  // BUSY & we_q is the first-cycle write strobe and it drops with Reset at once.
  always_comb begin
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    mem_we_o    = (state_q == StBusy) && we_q;
    owner_o     = owner_q;
    p_ack_o     = (state_q == StDone) && (owner_q == OwnP);
    d_ack_o     = (state_q == StDone) && (owner_q == OwnD);
    p_rdata_o   = p_rdata_q;
    d_rdata_o   = d_rdata_q;
    p_stall_o   = p_req_i && !p_ack_o;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model plus per-cycle compare and
// directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        CLK;
  logic        Reset;
  logic        p_req, p_we, d_req, d_we;
  logic [15:0] p_addr, p_wdata, d_addr, d_wdata;
  logic [15:0] p_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata;
  logic        p_ack_o, p_stall_o, d_ack_o, mem_we_o;
  logic [1:0]  owner_o;

  int total = 0;
  int bad = 0;
  int we_cycles = 0;
  int ack_log[$];

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
    .CLK(CLK), .Reset(Reset),
    .p_req_i(p_req), .p_we_i(p_we), .p_addr_i(p_addr), .p_wdata_i(p_wdata),
    .p_rdata_o(p_rdata_o), .p_ack_o(p_ack_o), .p_stall_o(p_stall_o),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
    .mem_rdata_i(mem_rdata), .owner_o(owner_o)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1);
  end

  // Initial memory contents
  function automatic logic [15:0] init_val(input logic [7:0] a);
    case (a)
      8'h10:   return 16'hBEEF;
      8'h20:   return 16'hCAFE;
      8'h99:   return 16'h9999;
      default: return {8'h5A, a};
    endcase
  endfunction

  // Memory device seen by the DUT
  logic [15:0] mem [256];
  bit          mem_wr [256];
  always @(posedge CLK) begin
    if (mem_we_o) begin
      mem[mem_addr_o[7:0]]    <= mem_wdata_o;
      mem_wr[mem_addr_o[7:0]] <= 1'b1;
    end
  end
  assign mem_rdata = mem_wr[mem_addr_o[7:0]] ? mem[mem_addr_o[7:0]] : init_val(mem_addr_o[7:0]);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  // m_age counts cycles since the grant: 1..m_lat on the bus, m_lat+1 is the ack cycle.
  logic        m_act, m_is_d, m_we, m_last_d;
  logic [15:0] m_addr, m_wdata, m_prd, m_drd;
  int          m_age, m_lat;
  logic [15:0] m_mem [256];
  bit          m_wr [256];

  function automatic logic [15:0] m_rd(input logic [7:0] a);
    return m_wr[a] ? m_mem[a] : init_val(a);
  endfunction

  function automatic bit pick_d(input bit pr, input bit dr, input bit last_d);
`ifdef ARB_RR_EN
    return dr && (!pr || !last_d);
`else
    return dr && !pr;
`endif
  endfunction

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      m_act    <= 1'b0;
      m_age    <= 0;
      m_is_d   <= 1'b0;
      m_we     <= 1'b0;
      m_prd    <= '0;
      m_drd    <= '0;
      m_last_d <= 1'b1;
    end else if (!m_act) begin
      if (p_req || d_req) begin
        m_act    <= 1'b1;
        m_age    <= 1;
        m_is_d   <= pick_d(p_req, d_req, m_last_d);
        m_last_d <= pick_d(p_req, d_req, m_last_d);
        m_addr   <= pick_d(p_req, d_req, m_last_d) ? d_addr : p_addr;
        m_wdata  <= pick_d(p_req, d_req, m_last_d) ? d_wdata : p_wdata;
        m_we     <= pick_d(p_req, d_req, m_last_d) ? d_we : p_we;
        m_lat    <= (pick_d(p_req, d_req, m_last_d) ? d_we : p_we) ? 1 : LAT;
      end
    end else begin
      if (m_age == m_lat && !m_we) begin
        if (m_is_d) m_drd <= m_rd(m_addr[7:0]);
        else        m_prd <= m_rd(m_addr[7:0]);
      end
      if (m_age == 1 && m_we) begin
        m_mem[m_addr[7:0]] <= m_wdata;
        m_wr[m_addr[7:0]]  <= 1'b1;
      end
      if (m_age == m_lat + 1) m_act <= 1'b0;
      else                    m_age <= m_age + 1;
    end
  end

  // Per-cycle compare against the model
  always @(negedge CLK) begin
    chk("owner", owner_o, m_act ? (m_is_d ? 2 : 1) : 0);
    chk("mem_we", mem_we_o, m_act && m_we && m_age == 1);
    chk("p_ack", p_ack_o, m_act && !m_is_d && m_age == m_lat + 1);
    chk("d_ack", d_ack_o, m_act && m_is_d && m_age == m_lat + 1);
    chk("p_rdata", p_rdata_o, m_prd);
    chk("d_rdata", d_rdata_o, m_drd);
    chk("p_stall", p_stall_o, p_req && !(m_act && !m_is_d && m_age == m_lat + 1));
    if (m_act && m_age <= m_lat) begin
      chk("mem_addr", mem_addr_o, m_addr);
      if (m_we) chk("mem_wdata", mem_wdata_o, m_wdata);
    end
    if (mem_we_o) we_cycles++;
    if (p_ack_o) ack_log.push_back(1);
    if (d_ack_o) ack_log.push_back(2);
  end

  // ---------------- requester tasks ----------------
  // lat = cycles from the sampling IDLE cycle to the ack cycle
  task automatic p_access(input bit we, input logic [15:0] a, input logic [15:0] w,
                          input bit drop, output int lat, output int st);
    bit seen = 1'b0;
    int n = 0;
    st = 0;
    @(posedge CLK);
    #1 p_req = 1'b1; p_we = we; p_addr = a; p_wdata = w;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (p_stall_o) st++;
      if (p_ack_o) seen = 1'b1;
      else n++;
      if (drop && i == 0) begin
        @(posedge CLK);
        #1 p_req = 1'b0; p_addr = 16'h0099;
      end
    end
    chk("p_ack_seen", seen, 1'b1);
    lat = n;
    @(posedge CLK);
    #1 p_req = 1'b0;
  endtask

  task automatic d_access(input bit we, input logic [15:0] a, input logic [15:0] w,
                          output int lat);
    bit seen = 1'b0;
    int n = 0;
    @(posedge CLK);
    #1 d_req = 1'b1; d_we = we; d_addr = a; d_wdata = w;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (d_ack_o) seen = 1'b1;
      else n++;
    end
    chk("d_ack_seen", seen, 1'b1);
    lat = n;
    @(posedge CLK);
    #1 d_req = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int lat, lat2, st, k;
    int exp_order[4];
`ifdef ARB_RR_EN
    exp_order = '{1, 2, 1, 2};
`else
    exp_order = '{1, 1, 1, 1};
`endif
    Reset = 1'b1;
    p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge CLK);
    #2 Reset = 1'b0;
    #1;
    chk("rst_owner", owner_o, 2'b00);
    chk("rst_mem_we", mem_we_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 16'h0000);
    chk("rst_mem_wdata", mem_wdata_o, 16'h0000);
    chk("rst_p_ack", p_ack_o, 1'b0);
    chk("rst_d_ack", d_ack_o, 1'b0);
    chk("rst_p_rdata", p_rdata_o, 16'h0000);
    chk("rst_d_rdata", d_rdata_o, 16'h0000);

    // P read from 0x0010
    p_access(1'b0, 16'h0010, 16'h0000, 1'b0, lat, st);
    chk("rd_lat", lat, 3);
    chk("rd_stall_cycles", st, 3);
    chk("rd_data", p_rdata_o, 16'hBEEF);

    // D write 0x1234 to 0x0040
    we_cycles = 0;
    d_access(1'b1, 16'h0040, 16'h1234, lat);
    chk("wr_lat", lat, 2);
    chk("wr_we_cycles", we_cycles, 1);
    chk("wr_mem", mem[8'h40], 16'h1234);

    // Simultaneous requests: P first, D one IDLE cycle after P's DONE
    ack_log.delete();
    fork
      p_access(1'b0, 16'h0020, 16'h0000, 1'b0, lat, st);
      d_access(1'b0, 16'h0010, 16'h0000, lat2);
    join
    chk("tie_p_lat", lat, 3);
    chk("tie_d_lat", lat2, 7);
    chk("tie_ack_count", ack_log.size(), 2);
    if (ack_log.size() == 2) begin
      chk("tie_first", ack_log[0], 1);
      chk("tie_second", ack_log[1], 2);
    end
    chk("tie_d_data", d_rdata_o, 16'hBEEF);

    // Reset during the first BUSY cycle of a D write
    @(posedge CLK);
    #1 d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0050; d_wdata = 16'h7777;
    @(posedge CLK);
    #1 chk("abort_we_before", mem_we_o, 1'b1);
    #1 Reset = 1'b1;
    #1 chk("abort_we", mem_we_o, 1'b0);
    chk("abort_owner", owner_o, 2'b00);
    d_req = 1'b0; d_we = 1'b0;
    repeat (2) @(posedge CLK);
    #2 Reset = 1'b0;
    p_access(1'b0, 16'h0010, 16'h0000, 1'b0, lat, st);
    chk("after_abort_lat", lat, 3);
    chk("after_abort_data", p_rdata_o, 16'hBEEF);
    chk("abort_no_write", mem_wr[8'h50], 1'b0);

    // P drops req and changes address after the grant
    p_access(1'b0, 16'h0020, 16'h0000, 1'b1, lat, st);
    chk("drop_lat", lat, 3);
    chk("drop_data", p_rdata_o, 16'hCAFE);

    // Both requesters held for four accesses, starting from reset
    @(posedge CLK);
    #2 Reset = 1'b1;
    @(posedge CLK);
    #2 Reset = 1'b0;
    ack_log.delete();
    @(posedge CLK);
    #1 p_req = 1'b1; p_we = 1'b0; p_addr = 16'h0030;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0031;
    k = 0;
    for (int i = 0; i < 60 && k < 4; i++) begin
      @(negedge CLK);
      if (p_ack_o || d_ack_o) k++;
    end
    chk("hold_acks_seen", k, 4);
    @(posedge CLK);
    #1 p_req = 1'b0; d_req = 1'b0;
    repeat (2) @(posedge CLK);
    #1 chk("hold_ack_count", ack_log.size(), 4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
      chk("hold_order", ack_log[i], exp_order[i]);
    end

    repeat (2) @(posedge CLK);
    #1 $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
